// File: rtl/arb_req_client_if.sv
// Client-facing, arbiter-facing and resource-facing signals of one requester.
interface arb_req_client_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    // Requester front end side
    modport slave (
        input  in_valid, in_data, gnt,
        output in_ready, req, out_valid, out_data
    );

    // Client / arbiter / resource side
    modport master (
        output in_valid, in_data, gnt,
        input  in_ready, req, out_valid, out_data
    );
endinterface

// File: rtl/arb_req_client.sv
// Requester front end for a two-input fixed-priority arbiter: buffers client
// commands, requests while work is pending, pops one command per granted
// cycle, yields after a capped burst and flags starvation.
module arb_req_client #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 16,
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    arb_req_client_if.slave  bus,
    output logic [LVL_W-1:0] level,
    output logic             starve
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BST_W = $clog2(MAX_BURST + 1);
    localparam int WAI_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {RUN, YIELD} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count, count_nxt;
    logic [BST_W-1:0]  burst_cnt;
    logic [WAI_W-1:0]  wait_cnt;
    logic              push, pop, cap_hit;

    // Full check ignores a same-cycle pop so in_ready is purely registered.
    assign bus.in_ready = (count != LVL_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    // A grant that arrives after the FIFO drained (arbiter lag) pops nothing.
    assign pop          = bus.gnt && (count != '0);
    assign bus.req      = (count != '0) && (state == RUN);
    assign level        = count;
    assign starve       = (wait_cnt == WAI_W'(STARVE_LIMIT));

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + LVL_W'(1);
        else if (!push && pop)
            count_nxt = count - LVL_W'(1);
    end

    // Capping pop forces a yield only if work remains; a drained FIFO drops
    // req anyway and the following gnt-low clears the burst count.
    assign cap_hit = (state == RUN) && pop &&
                     (burst_cnt == BST_W'(MAX_BURST - 1)) && (count_nxt != '0);

    // Next state: one-cycle YIELD after a capped burst.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cap_hit) state_nxt = YIELD;
            YIELD:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // Registered output beat; data holds between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= pop;
            if (pop) bus.out_data <= mem[rd_ptr];
        end
    end

    // Burst counter: counts pops in RUN, cleared by gnt low or any yield.
    // Lag pops during YIELD are not counted.
    always_ff @(posedge clk) begin
        if (reset)
            burst_cnt <= '0;
        else if (state == YIELD || cap_hit || !bus.gnt)
            burst_cnt <= '0;
        else if (pop && burst_cnt != BST_W'(MAX_BURST))
            burst_cnt <= burst_cnt + BST_W'(1);
    end

    // Wait counter: saturating count of requested-but-ungranted cycles.
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (bus.gnt || !bus.req)
            wait_cnt <= '0;
        else if (wait_cnt != WAI_W'(STARVE_LIMIT))
            wait_cnt <= wait_cnt + WAI_W'(1);
    end
endmodule

// File: tb/tb_arb_req_client.sv
// Two requesters on a modelled fixed-priority registered arbiter (client 0
// wins), checked every cycle against a queue-based reference model; output
// beats are checked against a scoreboard of accepted commands.
module tb_arb_req_client;
    localparam int DATA_W = 8, DEPTH = 4, MAX_BURST = 4, STARVE_LIMIT = 16;

    logic clk = 1'b0;
    logic reset;
    logic arb_en;
    logic [2:0] level0, level1;
    logic starve0, starve1;

    always #5 clk = ~clk;

    arb_req_client_if #(.DATA_W(DATA_W)) if0 ();
    arb_req_client_if #(.DATA_W(DATA_W)) if1 ();

    arb_req_client #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST),
                     .STARVE_LIMIT(STARVE_LIMIT)) u0 (
        .clk(clk), .reset(reset), .bus(if0), .level(level0), .starve(starve0));
    arb_req_client #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST),
                     .STARVE_LIMIT(STARVE_LIMIT)) u1 (
        .clk(clk), .reset(reset), .bus(if1), .level(level1), .starve(starve1));

    // Registered fixed-priority arbiter; deliberately not reset so an
    // in-flight grant can overlap a client reset.
    always @(posedge clk) begin
        if0.gnt <= arb_en && if0.req;
        if1.gnt <= arb_en && if1.req && !if0.req;
    end

    // ---------------- reference model ----------------
    logic [7:0] mq [2][$];   // pending commands
    logic [7:0] sb [2][$];   // scoreboard of expected output beats
    int  m_burst [2];
    int  m_wait  [2];
    bit  m_yld   [2];
    bit  m_ov    [2];
    logic [7:0] m_od [2];
    int n_vec = 0, n_err = 0;

    task automatic model_step(int c, bit iv, logic [7:0] id, bit g);
        bit r, rdy, p;
        if (reset) begin
            mq[c].delete(); sb[c].delete();
            m_burst[c] = 0; m_wait[c] = 0; m_yld[c] = 0;
            m_ov[c] = 0; m_od[c] = 8'h00;
            return;
        end
        r   = (mq[c].size() != 0) && !m_yld[c];
        rdy = (mq[c].size() != DEPTH);
        if (r && !g) m_wait[c] = (m_wait[c] < STARVE_LIMIT) ? m_wait[c] + 1 : STARVE_LIMIT;
        else         m_wait[c] = 0;
        p = g && (mq[c].size() != 0);
        m_ov[c] = p;
        if (p) m_od[c] = mq[c].pop_front();
        if (iv && rdy) begin
            mq[c].push_back(id);
            sb[c].push_back(id);
        end
        if (m_yld[c]) begin
            m_yld[c] = 0; m_burst[c] = 0;
        end else if (p && m_burst[c] == MAX_BURST - 1 && mq[c].size() != 0) begin
            m_yld[c] = 1; m_burst[c] = 0;
        end else if (!g) m_burst[c] = 0;
        else if (p)      m_burst[c]++;
    endtask

    always @(posedge clk) begin
        model_step(0, if0.in_valid, if0.in_data, if0.gnt);
        model_step(1, if1.in_valid, if1.in_data, if1.gnt);
    end

    task automatic check(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t got %0h expected %0h", name, c, $time, act, exp);
        end
    endtask

    task automatic check_client(int c, logic rq, logic rdy, logic ov,
                                logic [7:0] od, logic [2:0] lvl, logic st);
        logic [7:0] e;
        check("req",       c, 32'(rq),  32'((mq[c].size() != 0) && !m_yld[c]));
        check("in_ready",  c, 32'(rdy), 32'(mq[c].size() != DEPTH));
        check("level",     c, 32'(lvl), 32'(mq[c].size()));
        check("starve",    c, 32'(st),  32'(m_wait[c] == STARVE_LIMIT));
        check("out_valid", c, 32'(ov),  32'(m_ov[c]));
        check("out_data",  c, 32'(od),  32'(m_od[c]));
        // Scoreboard monitor: every beat must be the oldest accepted command.
        if (ov === 1'b1) begin
            if (sb[c].size() == 0) check("sb_extra_beat", c, 32'(od), 32'hFFFF_FFFF);
            else begin
                e = sb[c].pop_front();
                check("sb_order", c, 32'(od), 32'(e));
            end
        end
    endtask

    always @(negedge clk) begin
        check_client(0, if0.req, if0.in_ready, if0.out_valid, if0.out_data, level0, starve0);
        check_client(1, if1.req, if1.in_ready, if1.out_valid, if1.out_data, level1, starve1);
    end

    // ---------------- stimulus ----------------
    task automatic tick(); @(posedge clk); #2; endtask

    task automatic push0(int n, logic [7:0] base);
        if0.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if0.in_data = base + 8'(i);
            tick();
        end
        if0.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arb_en = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Single command through an idle arbiter.
        arb_en = 1'b1;
        push0(1, 8'hA5);
        repeat (8) tick();

        // No grants: fill, refuse the 5th word, reach starvation.
        arb_en = 1'b0;
        push0(5, 8'h10);
        repeat (20) tick();

        // Full FIFO with grant returning while input keeps offering.
        arb_en = 1'b1;
        if0.in_valid = 1'b1; if0.in_data = 8'h77;
        repeat (10) tick();
        if0.in_valid = 1'b0;
        repeat (10) tick();

        // Six back-to-back words: burst cap, yield, lag pop, resume.
        push0(6, 8'h20);
        repeat (15) tick();

        // Randomized traffic, client 0 heavily loaded.
        for (int i = 0; i < 3000; i++) begin
            if0.in_valid = ($urandom_range(0, 9) < 8);
            if0.in_data  = 8'($urandom);
            if1.in_valid = ($urandom_range(0, 9) < 4);
            if1.in_data  = 8'($urandom);
            tick();
        end
        if0.in_valid = 1'b0; if1.in_valid = 1'b0;
        repeat (20) tick();

        // Reset mid-operation with a grant in flight.
        arb_en = 1'b0;
        push0(3, 8'h40);
        arb_en = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        push0(1, 8'hA5);
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
